// File: rtl/nbr_pair_index_gen.sv
// Single/pair neighbour index enumerator with valid/ready backpressure.
// Optional accepted-beat counter is built when NBR_IDX_COUNT_EN is defined.
module nbr_pair_index_gen #(
  parameter int J      = 14,
  parameter int A      = 4,
  parameter int AWIDTH = $clog2(A) + 1,
  parameter int JW     = $clog2(J) + 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [J*AWIDTH-1:0]   x_init,
  input  logic                  x_init_valid,
  input  logic                  start,
  input  logic [1:0]            mode,
  input  logic [JW-1:0]         skip_idx,
  input  logic                  out_ready,
  output logic                  out_valid,
  output logic                  out_kind,
  output logic                  out_last,
  output logic [JW-1:0]         row0,
  output logic [JW-1:0]         row1,
  output logic [AWIDTH-1:0]     div_col0,
  output logic [AWIDTH-1:0]     div_col1,
  output logic [AWIDTH-1:0]     mul_col0,
  output logic [AWIDTH-1:0]     mul_col1,
  output logic                  busy,
  output logic                  done,
  output logic [15:0]           cand_count
);

  typedef enum logic [1:0] {
    S_IDLE, S_SINGLE, S_PAIR, S_DONE
  } state_e;

  typedef logic [AWIDTH-1:0] lvl_t;

  localparam logic [JW-1:0]   JJ  = JW'(J);
  localparam logic [JW-1:0]   JM1 = JW'(J - 1);
  localparam logic [JW-1:0]   JM2 = JW'(J - 2);
  localparam lvl_t            AM1 = AWIDTH'(A - 1);
  localparam lvl_t            D1  = AWIDTH'(1);
  localparam logic [AWIDTH:0] AA  = (AWIDTH + 1)'(A);
  localparam lvl_t            AL  = AWIDTH'(A);

  state_e        state_q, state_d;
  lvl_t          x_q [J];
  lvl_t          x_d [J];
  logic [1:0]    mode_q, mode_d;
  logic [JW-1:0] skip_q, skip_d;
  logic [JW-1:0] r0_q, r0_d, r1_q, r1_d;
  lvl_t          d0_q, d0_d, d1_q, d1_d;
  logic          valid_q, valid_d, kind_q, kind_d;
  logic          last_q, last_d, busy_q, busy_d;
  logic          done_q, done_d;
  logic [JW-1:0] row0_q, row0_d, row1_q, row1_d;
  lvl_t          dv0_q, dv0_d, dv1_q, dv1_d;
  lvl_t          ml0_q, ml0_d, ml1_q, ml1_d;
  logic          fire, ld, lk, clr;
  logic [JW-1:0] lr0, lr1, lst;
  lvl_t          ld0, ld1, xv0, xv1;

  function automatic lvl_t lvl_add(input lvl_t x, input lvl_t d);
    logic [AWIDTH:0] s;
    s = {1'b0, x} + {1'b0, d};
    if (s >= AA) s = s - AA;
    return s[AWIDTH-1:0];
  endfunction

  function automatic logic [JW-1:0] nxt(input logic [JW-1:0] r,
                                        input logic [JW-1:0] s);
    logic [JW-1:0] n;
    n = r + JW'(1);
    if (n == s) n = n + JW'(1);
    return n;
  endfunction

  function automatic logic [JW-1:0] first_row(input logic [JW-1:0] s);
    logic [JW-1:0] f;
    f = '0;
    if (s == '0) f = JW'(1);
    return f;
  endfunction

  function automatic logic [JW-1:0] last_row(input logic [JW-1:0] s);
    return (s == JM1) ? JM2 : JM1;
  endfunction

  // pair phase needs at least two rows left after the exclusion
  function automatic logic has_pair(input logic [1:0] m,
                                    input logic [JW-1:0] s);
    return (m != 2'b00) && ((J >= 3) || (s >= JJ));
  endfunction

  assign fire = valid_q & out_ready;

  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    mode_d  = mode_q;
    skip_d  = skip_q;
    r0_d    = r0_q;
    r1_d    = r1_q;
    d0_d    = d0_q;
    d1_d    = d1_q;
    valid_d = valid_q;
    kind_d  = kind_q;
    last_d  = last_q;
    row0_d  = row0_q;
    row1_d  = row1_q;
    dv0_d   = dv0_q;
    dv1_d   = dv1_q;
    ml0_d   = ml0_q;
    ml1_d   = ml1_q;
    done_d  = 1'b0;
    ld      = 1'b0;
    lk      = 1'b0;
    clr     = 1'b0;
    lr0     = r0_q;
    lr1     = r1_q;
    ld0     = d0_q;
    ld1     = d1_q;
    xv0     = '0;
    xv1     = '0;
    lst     = '0;

    unique case (state_q)
      S_IDLE: begin
        if (x_init_valid) begin
          for (int i = 0; i < J; i++) begin
            x_d[i] = (x_init[i*AWIDTH +: AWIDTH] >= AL) ?
                     '0 : x_init[i*AWIDTH +: AWIDTH];
          end
        end
        if (start) begin
          mode_d = mode;
          skip_d = skip_idx;
          if (mode != 2'b01) begin
            state_d = S_SINGLE;
            ld  = 1'b1;
            lr0 = first_row(skip_idx);
            lr1 = '0;
            ld0 = D1;
            ld1 = '0;
          end else if (has_pair(mode, skip_idx)) begin
            state_d = S_PAIR;
            ld  = 1'b1;
            lk  = 1'b1;
            lr0 = first_row(skip_idx);
            lr1 = nxt(first_row(skip_idx), skip_idx);
            ld0 = D1;
            ld1 = D1;
          end else begin
            state_d = S_DONE;
            done_d  = 1'b1;
          end
        end
      end
      S_SINGLE: begin
        if (fire) begin
          if (d0_q != AM1) begin
            ld  = 1'b1;
            ld0 = d0_q + D1;
          end else if (r0_q != last_row(skip_q)) begin
            ld  = 1'b1;
            lr0 = nxt(r0_q, skip_q);
            ld0 = D1;
          end else if (has_pair(mode_q, skip_q)) begin
            state_d = S_PAIR;
            ld  = 1'b1;
            lk  = 1'b1;
            lr0 = first_row(skip_q);
            lr1 = nxt(first_row(skip_q), skip_q);
            ld0 = D1;
            ld1 = D1;
          end else begin
            state_d = S_DONE;
            done_d  = 1'b1;
            clr     = 1'b1;
          end
        end
      end
      S_PAIR: begin
        if (fire) begin
          lk = 1'b1;
          if (d1_q != AM1) begin
            ld  = 1'b1;
            ld1 = d1_q + D1;
          end else if (d0_q != AM1) begin
            ld  = 1'b1;
            ld0 = d0_q + D1;
            ld1 = D1;
          end else if (r1_q != last_row(skip_q)) begin
            ld  = 1'b1;
            lr1 = nxt(r1_q, skip_q);
            ld0 = D1;
            ld1 = D1;
          end else if (nxt(r0_q, skip_q) != last_row(skip_q)) begin
            ld  = 1'b1;
            lr0 = nxt(r0_q, skip_q);
            lr1 = nxt(nxt(r0_q, skip_q), skip_q);
            ld0 = D1;
            ld1 = D1;
          end else begin
            state_d = S_DONE;
            done_d  = 1'b1;
            clr     = 1'b1;
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // levels always come from the stored assignment, never from old beats
    if (ld) begin
      for (int i = 0; i < J; i++) begin
        if (lr0 == JW'(i)) xv0 = x_q[i];
        if (lr1 == JW'(i)) xv1 = x_q[i];
      end
      lst     = last_row(skip_d);
      valid_d = 1'b1;
      kind_d  = lk;
      row0_d  = lr0;
      row1_d  = lk ? lr1 : '0;
      dv0_d   = xv0;
      ml0_d   = lvl_add(xv0, ld0);
      dv1_d   = lk ? xv1 : '0;
      ml1_d   = lk ? lvl_add(xv1, ld1) : '0;
      if (lk) begin
        last_d = (lr1 == lst) && (nxt(lr0, skip_d) == lst) &&
                 (ld0 == AM1) && (ld1 == AM1);
      end else begin
        last_d = (lr0 == lst) && (ld0 == AM1) &&
                 !has_pair(mode_d, skip_d);
      end
      r0_d = lr0;
      r1_d = lr1;
      d0_d = ld0;
      d1_d = ld1;
    end

    if (clr) begin
      valid_d = 1'b0;
      kind_d  = 1'b0;
      last_d  = 1'b0;
      row0_d  = '0;
      row1_d  = '0;
      dv0_d   = '0;
      dv1_d   = '0;
      ml0_d   = '0;
      ml1_d   = '0;
    end

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      x_q     <= '{default: '0};
      mode_q  <= '0;
      skip_q  <= '0;
      r0_q    <= '0;
      r1_q    <= '0;
      d0_q    <= '0;
      d1_q    <= '0;
      valid_q <= 1'b0;
      kind_q  <= 1'b0;
      last_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      row0_q  <= '0;
      row1_q  <= '0;
      dv0_q   <= '0;
      dv1_q   <= '0;
      ml0_q   <= '0;
      ml1_q   <= '0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      mode_q  <= mode_d;
      skip_q  <= skip_d;
      r0_q    <= r0_d;
      r1_q    <= r1_d;
      d0_q    <= d0_d;
      d1_q    <= d1_d;
      valid_q <= valid_d;
      kind_q  <= kind_d;
      last_q  <= last_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      row0_q  <= row0_d;
      row1_q  <= row1_d;
      dv0_q   <= dv0_d;
      dv1_q   <= dv1_d;
      ml0_q   <= ml0_d;
      ml1_q   <= ml1_d;
    end
  end

`ifdef NBR_IDX_COUNT_EN
  logic [15:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (state_q == S_IDLE && start) begin
      cnt_d = '0;
    end else if (fire && cnt_q != 16'hFFFF) begin
      cnt_d = cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign cand_count = cnt_q;
`else
  assign cand_count = '0;
`endif

  assign out_valid = valid_q;
  assign out_kind  = kind_q;
  assign out_last  = last_q;
  assign row0      = row0_q;
  assign row1      = row1_q;
  assign div_col0  = dv0_q;
  assign div_col1  = dv1_q;
  assign mul_col0  = ml0_q;
  assign mul_col1  = ml1_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule

// File: tb/tb_nbr_pair_index_gen.sv
// Bench for nbr_pair_index_gen: three instances (J/A variants) checked
// against a list-based enumeration model, table cases and random runs.
`timescale 1ns/1ps
module tb_nbr_pair_index_gen;

  typedef struct packed {
    logic       kind;
    logic       last;
    logic [7:0] r0;
    logic [7:0] r1;
    logic [7:0] dv0;
    logic [7:0] dv1;
    logic [7:0] ml0;
    logic [7:0] ml1;
  } beat_t;

  typedef struct {
    int r;
    int dv;
    int ml;
  } sv_t;

  typedef struct {
    int sel;
    int x0;
    int x1;
    int x2;
    int x3;
    int skip;
    int mode;
    int rp;
    int nb;
    int tab;
  } case_t;

`ifdef NBR_IDX_COUNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        x_init_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic [1:0]  mode = '0;
  logic [2:0]  skip = '0;
  logic [1:0]  sel = '0;
  logic [11:0] xi0 = '0;
  logic [7:0]  xi1 = '0;
  logic [3:0]  xi2 = '0;
  logic        st0, st1, st2;

  logic        v0, k0, l0, b0, dn0;
  logic [2:0]  ra0, rb0, da0, db0, ma0, mb0;
  logic [15:0] c0;
  logic        v1, k1, l1, b1, dn1;
  logic [2:0]  ra1, rb1;
  logic [1:0]  da1, db1, ma1, mb1;
  logic [15:0] c1;
  logic        v2, k2, l2, b2, dn2;
  logic [1:0]  ra2, rb2, da2, db2, ma2, mb2;
  logic [15:0] c2;

  beat_t       cur;
  logic        ov, ob, od;
  logic [15:0] oc;

  beat_t       exp_q[$];
  int          n_vec = 0;
  int          n_bad = 0;
  case_t       cs[10];
  sv_t         tab6[6];

  always #5 clk = ~clk;

  assign st0 = start & (sel == 2'd0);
  assign st1 = start & (sel == 2'd1);
  assign st2 = start & (sel == 2'd2);

  nbr_pair_index_gen #(.J(4), .A(3)) u0 (
    .clk(clk), .rst(rst), .x_init(xi0), .x_init_valid(x_init_valid),
    .start(st0), .mode(mode), .skip_idx(skip), .out_ready(out_ready),
    .out_valid(v0), .out_kind(k0), .out_last(l0), .row0(ra0), .row1(rb0),
    .div_col0(da0), .div_col1(db0), .mul_col0(ma0), .mul_col1(mb0),
    .busy(b0), .done(dn0), .cand_count(c0));

  nbr_pair_index_gen #(.J(4), .A(2)) u1 (
    .clk(clk), .rst(rst), .x_init(xi1), .x_init_valid(x_init_valid),
    .start(st1), .mode(mode), .skip_idx(skip), .out_ready(out_ready),
    .out_valid(v1), .out_kind(k1), .out_last(l1), .row0(ra1), .row1(rb1),
    .div_col0(da1), .div_col1(db1), .mul_col0(ma1), .mul_col1(mb1),
    .busy(b1), .done(dn1), .cand_count(c1));

  nbr_pair_index_gen #(.J(2), .A(2)) u2 (
    .clk(clk), .rst(rst), .x_init(xi2), .x_init_valid(x_init_valid),
    .start(st2), .mode(mode), .skip_idx(skip[1:0]), .out_ready(out_ready),
    .out_valid(v2), .out_kind(k2), .out_last(l2), .row0(ra2), .row1(rb2),
    .div_col0(da2), .div_col1(db2), .mul_col0(ma2), .mul_col1(mb2),
    .busy(b2), .done(dn2), .cand_count(c2));

  always_comb begin
    cur = '0;
    ov  = 1'b0;
    ob  = 1'b0;
    od  = 1'b0;
    oc  = '0;
    case (sel)
      2'd0: begin
        cur.kind = k0; cur.last = l0;
        cur.r0 = 8'(ra0); cur.r1 = 8'(rb0);
        cur.dv0 = 8'(da0); cur.dv1 = 8'(db0);
        cur.ml0 = 8'(ma0); cur.ml1 = 8'(mb0);
        ov = v0; ob = b0; od = dn0; oc = c0;
      end
      2'd1: begin
        cur.kind = k1; cur.last = l1;
        cur.r0 = 8'(ra1); cur.r1 = 8'(rb1);
        cur.dv0 = 8'(da1); cur.dv1 = 8'(db1);
        cur.ml0 = 8'(ma1); cur.ml1 = 8'(mb1);
        ov = v1; ob = b1; od = dn1; oc = c1;
      end
      default: begin
        cur.kind = k2; cur.last = l2;
        cur.r0 = 8'(ra2); cur.r1 = 8'(rb2);
        cur.dv0 = 8'(da2); cur.dv1 = 8'(db2);
        cur.ml0 = 8'(ma2); cur.ml1 = 8'(mb2);
        ov = v2; ob = b2; od = dn2; oc = c2;
      end
    endcase
  end

  task automatic chk(input string nm, input longint act, input longint exp);
    n_vec++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  // Reference: list of non-excluded rows, then nested enumeration loops.
  task automatic build_exp(input case_t c);
    int    jn, an;
    int    raw[4];
    int    xs[4];
    int    e[$];
    beat_t b;
    jn = (c.sel == 2) ? 2 : 4;
    an = (c.sel == 0) ? 3 : 2;
    raw = '{c.x0, c.x1, c.x2, c.x3};
    for (int i = 0; i < 4; i++) xs[i] = (raw[i] >= an) ? 0 : raw[i];
    exp_q.delete();
    for (int r = 0; r < jn; r++) if (r != c.skip) e.push_back(r);
    if (c.mode != 1) begin
      foreach (e[i]) begin
        for (int d = 1; d < an; d++) begin
          b = '0;
          b.r0 = 8'(e[i]);
          b.dv0 = 8'(xs[e[i]]);
          b.ml0 = 8'((xs[e[i]] + d) % an);
          exp_q.push_back(b);
        end
      end
    end
    if (c.mode != 0 && e.size() >= 2) begin
      for (int i = 0; i < e.size(); i++) begin
        for (int k = i + 1; k < e.size(); k++) begin
          for (int d0 = 1; d0 < an; d0++) begin
            for (int d1 = 1; d1 < an; d1++) begin
              b = '0;
              b.kind = 1'b1;
              b.r0 = 8'(e[i]);
              b.r1 = 8'(e[k]);
              b.dv0 = 8'(xs[e[i]]);
              b.dv1 = 8'(xs[e[k]]);
              b.ml0 = 8'((xs[e[i]] + d0) % an);
              b.ml1 = 8'((xs[e[k]] + d1) % an);
              exp_q.push_back(b);
            end
          end
        end
      end
    end
    if (c.tab != 0) begin
      exp_q.delete();
      for (int i = 0; i < 6; i++) begin
        b = '0;
        b.r0 = 8'(tab6[i].r);
        b.dv0 = 8'(tab6[i].dv);
        b.ml0 = 8'(tab6[i].ml);
        exp_q.push_back(b);
      end
    end
    if (exp_q.size() > 0) begin
      b = exp_q.pop_back();
      b.last = 1'b1;
      exp_q.push_back(b);
    end
  endtask

  task automatic load_and_start(input case_t c);
    int raw[4];
    raw = '{c.x0, c.x1, c.x2, c.x3};
    sel = 2'(c.sel);
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      xi0[i*3 +: 3] = 3'(raw[i]);
      xi1[i*2 +: 2] = 2'(raw[i]);
    end
    xi2 = {2'(raw[1]), 2'(raw[0])};
    x_init_valid = 1'b1;
    @(negedge clk);
    x_init_valid = 1'b0;
    start = 1'b1;
    mode = 2'(c.mode);
    skip = 3'(c.skip);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic run_case(input case_t c);
    int    idx, cyc, ph, nb;
    bit    stalled, rdy;
    beat_t hold;
    build_exp(c);
    nb = (c.nb < 0) ? exp_q.size() : c.nb;
    load_and_start(c);
    chk("busy_after_start", ob, 1);
    chk("valid_first", ov, (exp_q.size() > 0) ? 1 : 0);
    idx = 0; cyc = 0; ph = 0; stalled = 0; hold = '0;
    while (idx < exp_q.size() && cyc < 400) begin
      chk("valid_run", ov, 1);
      if (stalled) chk("stable", cur, hold);
      case (c.rp)
        0:       rdy = 1'b1;
        1:       rdy = (ph % 3 == 0);
        default: rdy = ($urandom % 2) == 1;
      endcase
      ph++;
      out_ready = rdy;
      if (rdy) begin
        chk($sformatf("beat%0d", idx), cur, exp_q[idx]);
        idx++;
        stalled = 0;
      end else begin
        hold = cur;
        stalled = 1;
      end
      @(negedge clk);
      cyc++;
    end
    out_ready = 1'b0;
    if (cyc >= 400) begin
      n_vec++;
      n_bad++;
      $display("FAIL timeout: got %0d beats want %0d", idx, nb);
    end
    chk("done_pulse", od, 1);
    chk("valid_at_done", ov, 0);
    chk("busy_at_done", ob, 1);
    chk("count_at_done", oc, CNT_EN ? nb : 0);
    chk("beat_total", idx, nb);
    @(negedge clk);
    chk("done_clear", od, 0);
    chk("busy_clear", ob, 0);
    chk("count_hold", oc, CNT_EN ? nb : 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running want finished");
    $fatal(1, "global timeout");
  end

  initial begin
    case_t c;
    tab6[0] = '{0, 0, 1};
    tab6[1] = '{0, 0, 2};
    tab6[2] = '{2, 2, 0};
    tab6[3] = '{2, 2, 1};
    tab6[4] = '{3, 0, 1};
    tab6[5] = '{3, 0, 2};
    //         sel x0 x1 x2 x3 skip mode rp  nb tab
    cs[0] = '{0, 0, 1, 2, 0, 1, 0, 0, 6, 1};
    cs[1] = '{0, 0, 1, 2, 0, 1, 1, 0, 12, 0};
    cs[2] = '{1, 0, 1, 1, 0, 7, 2, 0, 10, 0};
    cs[3] = '{0, 0, 1, 2, 0, 1, 0, 1, 6, 1};
    cs[4] = '{0, 2, 0, 1, 5, 3, 3, 0, 18, 0};
    cs[5] = '{1, 1, 0, 1, 1, 0, 0, 1, 3, 0};
    cs[6] = '{2, 1, 0, 0, 0, 3, 2, 0, 3, 0};
    cs[7] = '{2, 1, 1, 0, 0, 1, 3, 1, 1, 0};
    cs[8] = '{0, 1, 1, 1, 1, 4, 1, 2, 24, 0};
    cs[9] = '{2, 0, 1, 0, 0, 0, 1, 0, 0, 0};

    repeat (3) @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      sel = 2'(k);
      #1;
      chk($sformatf("reset_beat%0d", k), cur, 0);
      chk($sformatf("reset_flags%0d", k), {ov, od, ob, oc}, 0);
    end
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 10; i++) run_case(cs[i]);

    // empty run: done at t+1, start during DONE ignored
    c = cs[9];
    load_and_start(c);
    chk("empty_done", od, 1);
    chk("empty_valid", ov, 0);
    start = 1'b1;
    mode = 2'b00;
    @(negedge clk);
    start = 1'b0;
    chk("empty_idle_busy", ob, 0);
    chk("empty_idle_valid", ov, 0);
    chk("empty_idle_done", od, 0);
    @(negedge clk);
    chk("empty_ignored", {ov, ob}, 0);

    // reset while beat 3 of the pair-only run is presented
    c = cs[1];
    build_exp(c);
    load_and_start(c);
    out_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("pre_rst_beat%0d", i), cur, exp_q[i]);
      @(negedge clk);
    end
    chk("pre_rst_beat2", cur, exp_q[2]);
    out_ready = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    chk("rst_beat", cur, 0);
    chk("rst_flags", {ov, od, ob, oc}, 0);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_no_done", {od, ov, ob}, 0);
    run_case(cs[1]);

    for (int it = 0; it < 25; it++) begin
      c.sel  = int'($urandom % 2);
      c.x0   = int'($urandom % ((c.sel == 0) ? 8 : 4));
      c.x1   = int'($urandom % ((c.sel == 0) ? 8 : 4));
      c.x2   = int'($urandom % ((c.sel == 0) ? 8 : 4));
      c.x3   = int'($urandom % ((c.sel == 0) ? 8 : 4));
      c.skip = int'($urandom % 8);
      c.mode = int'($urandom % 4);
      c.rp   = 2;
      c.nb   = -1;
      c.tab  = 0;
      run_case(c);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
